// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the FIFO write-side control blocks.
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int BURST_DEFAULT = 4;
    localparam int CNT_W         = 8;

    function automatic logic [1:0] grant_of(input arb_state_t s);
        case (s)
            OWN0:    return 2'b01;
            OWN1:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO with show-ahead read data; latency: one cycle push to visible.
// Backpressure: push is ignored while full, pop is ignored while empty.
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]   PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]     CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Two-way round-robin tie-break: purely combinational, no state, no backpressure.
// On a tie the requester that was not served most recently wins.
module rr_pick (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last1,
    output logic [1:0] win
);
    always_comb begin
        win = 2'b00;
        if (valid0 && valid1) begin
            win = last1 ? 2'b01 : 2'b10;
        end else if (valid0) begin
            win = 2'b01;
        end else if (valid1) begin
            win = 2'b10;
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst arbiter merging two requesters onto one FIFO write port; first write one cycle after grant.
// Backpressure: fifo_full drops the owner's ready and freezes state and burst count.
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int BURST = BURST_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    input  logic            fifo_full,
    output logic            fifo_we,
    output logic [XLEN-1:0] fifo_din,
    output logic [1:0]      grant
);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             last1;
    logic             last1_nxt;
    logic [1:0]       win;
    logic             xfer0;
    logic             xfer1;
    logic             own_valid;
    logic             other_valid;
    logic             burst_done;

    rr_pick u_pick (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .last1  (last1),
        .win    (win)
    );

    assign xfer0 = (state == OWN0) && !fifo_full && req0_valid;
    assign xfer1 = (state == OWN1) && !fifo_full && req1_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            last1 <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last1 <= last1_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        last1_nxt   = last1;
        own_valid   = (state == OWN1) ? req1_valid : req0_valid;
        other_valid = (state == OWN1) ? req0_valid : req1_valid;
        burst_done  = (xfer0 || xfer1) && ((cnt + CNT_W'(1)) == BURST_LAST);
        case (state)
            IDLE: begin
                if (win[0]) begin
                    state_nxt = OWN0;
                    cnt_nxt   = '0;
                    last1_nxt = 1'b0;
                end else if (win[1]) begin
                    state_nxt = OWN1;
                    cnt_nxt   = '0;
                    last1_nxt = 1'b1;
                end
            end
            OWN0, OWN1: begin
                // A dropped owner valid releases even while the FIFO is full.
                if (burst_done || !own_valid) begin
                    cnt_nxt = '0;
                    if (other_valid) begin
                        state_nxt = (state == OWN0) ? OWN1 : OWN0;
                        last1_nxt = (state == OWN0);
                    end else if (!own_valid) begin
                        state_nxt = IDLE;
                    end
                end else if (xfer0 || xfer1) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        grant      = grant_of(state);
        req0_ready = (state == OWN0) && !fifo_full;
        req1_ready = (state == OWN1) && !fifo_full;
        fifo_we    = xfer0 || xfer1;
        fifo_din   = xfer0 ? req0_data : (xfer1 ? req1_data : '0);
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter, alone and feeding a 4-deep FIFO.
module tb_fifo_wr_arbiter;
    localparam int XLEN  = 32;
    localparam int BURST = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            req0_valid;
    logic            req1_valid;
    logic [XLEN-1:0] req0_data;
    logic [XLEN-1:0] req1_data;
    logic            req0_ready;
    logic            req1_ready;
    logic            force_full;
    logic            fifo_full;
    logic            fifo_we;
    logic [XLEN-1:0] fifo_din;
    logic [1:0]      grant;
    logic            pop;
    logic            sys_mode;
    logic            q_full;
    logic            q_empty;
    logic [XLEN-1:0] q_data;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: owner -1 = none, words used in current grant, last owner.
    int              m_owner;
    int              m_used;
    int              m_last;
    int              idx0;
    int              idx1;
    logic [XLEN-1:0] base0;
    logic [XLEN-1:0] base1;
    logic [XLEN-1:0] sysq[$];
    logic [XLEN-1:0] dut_log[$];
    logic [1:0]      e_grant;
    logic            e_r0;
    logic            e_r1;
    logic            e_we;
    logic [XLEN-1:0] e_din;
    logic [XLEN-1:0] din_m;
    logic [36:0]     obs_v;
    logic [36:0]     exp_v;

    always #5 clk = ~clk;
    assign fifo_full = force_full | q_full;

    fifo_wr_arbiter #(.XLEN(XLEN), .BURST(BURST)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .fifo_full  (fifo_full),
        .fifo_we    (fifo_we),
        .fifo_din   (fifo_din),
        .grant      (grant)
    );

    fifo #(.WIDTH(XLEN), .DEPTH(4)) u_q (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_we),
        .push_data (fifo_din),
        .pop       (pop),
        .pop_data  (q_data),
        .full      (q_full),
        .empty     (q_empty)
    );

    task automatic model_eval();
        logic full_m;
        if (!reset) begin
            m_owner = -1; m_used = 0; m_last = 1;
        end
        full_m  = force_full || (sys_mode && sysq.size() == 4);
        e_r0    = reset && (m_owner == 0) && !full_m;
        e_r1    = reset && (m_owner == 1) && !full_m;
        e_we    = (e_r0 && req0_valid) || (e_r1 && req1_valid);
        e_din   = !e_we ? '0 : ((m_owner == 0) ? req0_data : req1_data);
        e_grant = (m_owner == 0) ? 2'b01 : ((m_owner == 1) ? 2'b10 : 2'b00);
    endtask

    task automatic model_commit();
        logic ov;
        logic xv;
        if (!reset) begin
            m_owner = -1; m_used = 0; m_last = 1;
            sysq.delete();
            return;
        end
        if (sys_mode && pop && sysq.size() > 0) void'(sysq.pop_front());
        if (e_we) begin
            if (sys_mode) sysq.push_back(e_din);
            if (m_owner == 0) idx0++; else idx1++;
            m_used++;
        end
        if (m_owner < 0) begin
            if (req0_valid && req1_valid) m_owner = 1 - m_last;
            else if (req0_valid)          m_owner = 0;
            else if (req1_valid)          m_owner = 1;
            if (m_owner >= 0) begin
                m_used = 0; m_last = m_owner;
            end
        end else begin
            ov = (m_owner == 0) ? req0_valid : req1_valid;
            xv = (m_owner == 0) ? req1_valid : req0_valid;
            if (m_used == BURST || !ov) begin
                m_used = 0;
                if (xv) begin
                    m_owner = 1 - m_owner; m_last = m_owner;
                end else if (!ov) begin
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
        if (fifo_we) dut_log.push_back(fifo_din);
        din_m = (e_we || e_grant == 2'b00) ? fifo_din : '0;
        obs_v = {grant, req0_ready, req1_ready, fifo_we, din_m};
        exp_v = {e_grant, e_r0, e_r1, e_we, e_din};
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
        req0_data = base0 + XLEN'(idx0);
        req1_data = base1 + XLEN'(idx1);
    endtask

    task automatic do_reset(input logic [XLEN-1:0] b0, input logic [XLEN-1:0] b1);
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        force_full = 1'b0; pop = 1'b1; sys_mode = 1'b0;
        base0 = b0; base1 = b1; idx0 = 0; idx1 = 0;
        req0_data = b0; req1_data = b1;
        m_owner = -1; m_used = 0; m_last = 1;
        sysq.delete(); dut_log.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset(32'h10, 32'h20);
        for (int c = 0; c < 4; c++) begin
            req0_valid = 1'($urandom); req1_valid = 1'($urandom); force_full = 1'($urandom);
            sample();
            n_cmp++;
            if (obs_v !== 37'h0) begin
                n_err++; $display("FAIL reset_outputs c=%0d got=%h want=%h", c, obs_v, 37'h0);
            end
            advance();
        end
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; force_full = 1'b0;
        sample();
        n_cmp++;
        if (obs_v !== exp_v) begin
            n_err++; $display("FAIL reset_idle got=%h want=%h", obs_v, exp_v);
        end
        advance();
    endtask

    task automatic test_tie_burst();
        do_reset(32'hA0, 32'hD0);
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            sample();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++; $display("FAIL tie_model c=%0d got=%h want=%h", c, obs_v, exp_v);
            end
            if (c == 1 || c == 5) begin
                n_cmp++;
                if (grant !== ((c == 1) ? 2'b01 : 2'b10)) begin
                    n_err++; $display("FAIL tie_grant c=%0d got=%b want=%b", c, grant, (c == 1) ? 2'b01 : 2'b10);
                end
            end
            advance();
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dut_log.size() <= i || dut_log[i] !== XLEN'(32'hA0 + i)) begin
                n_err++; $display("FAIL tie_word i=%0d got=%h want=%h", i,
                                  (dut_log.size() > i) ? dut_log[i] : 'x, XLEN'(32'hA0 + i));
            end
        end
    endtask

    task automatic test_single_wrap();
        do_reset(32'h70, 32'hB0);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            req0_valid = 1'b0; req1_valid = (idx1 < 6);
            sample();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++; $display("FAIL wrap_model c=%0d got=%h want=%h", c, obs_v, exp_v);
            end
            if (c >= 1 && c <= 6) begin
                n_cmp++;
                if ({grant, fifo_we} !== 3'b101) begin
                    n_err++; $display("FAIL wrap_grant_we c=%0d got=%b want=101", c, {grant, fifo_we});
                end
            end
            advance();
        end
        n_cmp++;
        if (dut_log.size() != 6) begin
            n_err++; $display("FAIL wrap_count got=%0d want=6", dut_log.size());
        end
        for (int i = 0; i < dut_log.size() && i < 6; i++) begin
            n_cmp++;
            if (dut_log[i] !== XLEN'(32'hB0 + i)) begin
                n_err++; $display("FAIL wrap_word i=%0d got=%h want=%h", i, dut_log[i], XLEN'(32'hB0 + i));
            end
        end
    endtask

    task automatic test_full_hold();
        do_reset(32'hC0, 32'hE0);
        reset = 1'b1;
        for (int c = 0; c < 7; c++) begin
            req0_valid = (idx0 < 1); req1_valid = 1'b0; force_full = (c >= 1 && c <= 3);
            sample();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++; $display("FAIL full_model c=%0d got=%h want=%h", c, obs_v, exp_v);
            end
            if (c >= 1 && c <= 3) begin
                n_cmp++;
                if ({grant, req0_ready, fifo_we} !== 4'b0100) begin
                    n_err++; $display("FAIL full_hold c=%0d got=%b want=0100", c, {grant, req0_ready, fifo_we});
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (fifo_we !== 1'b1 || fifo_din !== 32'hC0) begin
                    n_err++; $display("FAIL full_release we=%b din=%h want we=1 din=c0", fifo_we, fifo_din);
                end
            end
            advance();
        end
        force_full = 1'b0;
    endtask

    task automatic test_drop_switch();
        do_reset(32'hA0, 32'hB0);
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req0_valid = (idx0 < 2); req1_valid = 1'b1;
            sample();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++; $display("FAIL drop_model c=%0d got=%h want=%h", c, obs_v, exp_v);
            end
            if (c >= 1 && c <= 4) begin
                n_cmp++;
                if (grant === 2'b00) begin
                    n_err++; $display("FAIL drop_no_idle c=%0d got=%b want=nonzero", c, grant);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if ({grant, fifo_we, fifo_din} !== {2'b10, 1'b1, 32'hB0}) begin
                    n_err++; $display("FAIL drop_switch got=%b/%b/%h want=10/1/b0", grant, fifo_we, fifo_din);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        do_reset(32'h50, 32'h60);
        for (int c = 0; c < 7; c++) begin
            reset = !(c == 3); req0_valid = 1'b1; req1_valid = 1'b0;
            sample();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++; $display("FAIL rmid_model c=%0d got=%h want=%h", c, obs_v, exp_v);
            end
            if (c == 3) begin
                n_cmp++;
                if ({grant, req0_ready, req1_ready, fifo_we, fifo_din} !== 37'h0) begin
                    n_err++; $display("FAIL rmid_zero got=%b/%b/%b/%b/%h want=0", grant, req0_ready, req1_ready, fifo_we, fifo_din);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (grant !== 2'b00 || dut_log.size() != 2) begin
                    n_err++; $display("FAIL rmid_idle grant=%b writes=%0d want grant=00 writes=2", grant, dut_log.size());
                end
            end
            advance();
        end
    endtask

    task automatic test_system();
        int popped = 0;
        do_reset(32'h01, 32'h05);
        sys_mode = 1'b1; reset = 1'b1;
        for (int c = 0; c < 300 && popped < 8; c++) begin
            req0_valid = (idx0 < 4) && ($urandom_range(0, 3) != 0);
            req1_valid = (idx1 < 4) && ($urandom_range(0, 3) != 0);
            pop = 1'($urandom);
            sample();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++; $display("FAIL sys_model c=%0d got=%h want=%h", c, obs_v, exp_v);
            end
            n_cmp++;
            if (q_empty !== (sysq.size() == 0)) begin
                n_err++; $display("FAIL sys_empty c=%0d got=%b want=%b", c, q_empty, sysq.size() == 0);
            end
            if (pop && sysq.size() > 0) begin
                n_cmp++;
                if (q_data !== sysq[0]) begin
                    n_err++; $display("FAIL sys_read c=%0d got=%h want=%h", c, q_data, sysq[0]);
                end
                popped++;
            end
            advance();
        end
        n_cmp++;
        if (popped != 8) begin
            n_err++; $display("FAIL sys_timeout popped=%0d want=8", popped);
        end
        sys_mode = 1'b0; pop = 1'b1;
    endtask

    task automatic test_random();
        do_reset(XLEN'($urandom), XLEN'($urandom));
        for (int c = 0; c < 400; c++) begin
            reset      = ($urandom_range(0, 49) != 0);
            req0_valid = ($urandom_range(0, 9) < 7);
            req1_valid = ($urandom_range(0, 9) < 7);
            force_full = ($urandom_range(0, 4) == 0);
            sample();
            n_cmp++;
            if (obs_v !== exp_v) begin
                n_err++; $display("FAIL rand_model c=%0d got=%h want=%h", c, obs_v, exp_v);
            end
            advance();
        end
    endtask

    initial begin
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0; force_full = 1'b0; pop = 1'b1; sys_mode = 1'b0;
        test_reset();
        test_tie_burst();
        test_single_wrap();
        test_full_hold();
        test_drop_switch();
        test_reset_mid();
        test_system();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data word width.
REQ-002 Parameter BURST, default 4, maximum words one requester may push per grant; legal range 1..255.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 Port req0_valid  input  1  requester 0 offers a word.
REQ-006 Port req0_data  input  XLEN  requester 0 word.
REQ-007 Port req0_ready  output  1  requester 0 word accepted this cycle when valid.
REQ-008 Port req1_valid  input  1  requester 1 offers a word.
REQ-009 Port req1_data  input  XLEN  requester 1 word.
REQ-010 Port req1_ready  output  1  requester 1 word accepted this cycle when valid.
REQ-011 Port fifo_full  input  1  full flag of the downstream FIFO.
REQ-012 Port fifo_we  output  1  write enable to the downstream FIFO.
REQ-013 Port fifo_din  output  XLEN  write data to the downstream FIFO.
REQ-014 Port grant  output  2  one-hot current owner; bit0 = req0, bit1 = req1, 00 = none.

Function
REQ-015 States IDLE, OWN0, OWN1; grant SHALL be 01 in OWN0, 10 in OWN1, 00 in IDLE.
REQ-016 reqN_ready SHALL be 1 only in OWNN with fifo_full=0; ready SHALL NOT depend on reqN_valid.
REQ-017 A transfer occurs when reqN_valid and reqN_ready are both 1; fifo_we SHALL equal transfer; fifo_din SHALL equal owner's data, else 0.
REQ-018 Non-owner ready SHALL be 0 in every state.
REQ-019 IDLE: one valid -> own that requester next cycle; both valid -> own the requester not served last; none -> stay.
REQ-020 Latency: valid asserted in IDLE gives first transfer one cycle later; no transfer ever in IDLE.
REQ-021 A burst counter (8 bit) SHALL clear on entering an OWN state and increment on each transfer.
REQ-022 Release when transfer makes count = BURST, or owner valid = 0: switch directly to other OWN state if other valid, else retain owner (counter cleared) if owner still valid, else IDLE.
REQ-023 fifo_full=1 SHALL hold state and counter; ownership is not released by full alone.
REQ-024 Owner dropping valid while fifo_full=1 SHALL release per REQ-022.
REQ-025 A last-served flag SHALL record the most recent owner on every OWN entry.
REQ-026 Data SHALL never be duplicated or dropped: each accepted word produces exactly one fifo_we pulse in the same cycle.

Reset
REQ-027 reset=0 SHALL immediately force IDLE, counter 0, last-served = req1 (req0 wins first tie).
REQ-028 While in reset: fifo_we=0, fifo_din=0, req0_ready=0, req1_ready=0, grant=00.
REQ-029 Reset mid-burst SHALL abort the burst; no transfer in the cycle reset is asserted.

Structure
REQ-030 State enum arb_state_t and default BURST constant SHALL reside in the shared fifo_ctrl_pkg package.
REQ-031 Tie-break logic SHALL be one sub-module rr_pick (inputs two valids + last-served, output one-hot winner).
REQ-032 Arbiter SHALL NOT instantiate the FIFO; it drives the FIFO write port at the parent level.

Verification
REQ-033 Reset release, both valid idle -> grant=01 after one edge; req0 words 0xA0..0xA3 written, then grant=10.
REQ-034 Only req1 valid continuously, 6 words 0xB0..0xB5 -> all 6 written in order, counter wraps at 4, grant stays 10.
REQ-035 Owner req0 with fifo_full=1 for 3 cycles -> ready=0, fifo_we=0, grant holds 01, word 0xC0 written on full deassert.
REQ-036 req0 drops valid after 2 words while req1 valid -> grant 10 next cycle, no IDLE cycle.
REQ-037 Assert reset mid-burst after 2 of 4 words -> outputs 0 same cycle, IDLE after release; no extra fifo_we.
REQ-038 Arbiter + FIFO (LENGTH 4) system: interleaved bursts 0x01..0x08 -> FIFO read order matches grant order exactly.
